// File: rtl/instr_encode_loader.sv
// Program loader: accepts instruction fields over valid/ready, encodes them as
// MIPS words (lw/sw/R-type/addi/beq/j) and writes them sequentially to imem.
module instr_encode_loader #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 64,
    localparam int               CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(DEPTH - 1);

    state_t            state;
    logic              xfer;
    logic              legal;
    logic [ADDR_W-1:0] offset;

    function automatic logic [31:0] encode(
        input logic [2:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] word;
        case (kind)
            3'd0:    word = {6'b100011, rs, rt, imm};
            3'd1:    word = {6'b101011, rs, rt, imm};
            3'd2:    word = {6'b000000, rs, rt, rd, shamt, funct};
            3'd3:    word = {6'b001000, rs, rt, imm};
            3'd4:    word = {6'b000100, rs, rt, imm};
            3'd5:    word = {6'b000010, target};
            default: word = 32'h0;
        endcase
        return word;
    endfunction

    assign in_ready = (state == LOAD) && (word_cnt < DEPTH_C);
    assign xfer     = in_valid && in_ready;
    assign legal    = (in_kind < 3'd6);
    // Byte offset of the next word; wraps naturally at ADDR_W bits.
    assign offset   = ADDR_W'(word_cnt) << 2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'h0;
            word_cnt   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        word_cnt <= '0;
                        err      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        if (legal) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= BASE_ADDR + offset;
                            imem_wdata <= encode(in_kind, in_rs, in_rt, in_rd,
                                                 in_shamt, in_funct, in_imm, in_target);
                            word_cnt   <= word_cnt + 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    // finish outranks start; the word that fills memory also closes the session
                    if (finish || (xfer && legal && (word_cnt == DEPTH_M1))) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state    <= LOAD;
                        done     <= 1'b0;
                        word_cnt <= '0;
                        err      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: table of known encodings, hand sequences for
// illegal/full/finish/reset corners, and random traffic against a session model.
module tb_instr_encode_loader;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        finish;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [2:0]  word_cnt;
    logic        done;
    logic        err;

    instr_encode_loader #(
        .ADDR_W   (32),
        .BASE_ADDR(32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .finish    (finish),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_funct  (in_funct),
        .in_imm    (in_imm),
        .in_target (in_target),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .word_cnt  (word_cnt),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;

    // Session-level reference: is a session open, has one ever been opened,
    // how many words were written, and the last write seen on the bus.
    bit          m_open;
    bit          m_seen;
    bit          m_err;
    bit          m_we;
    int          m_cnt;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input int kind, input int rs, input int rt,
                                             input int rd, input int sh, input int fn,
                                             input int imm, input int tgt);
        int unsigned ops[6] = '{32'h23, 32'h2B, 32'h00, 32'h08, 32'h04, 32'h02};
        int unsigned w;
        if (kind == 2)
            w = rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + sh * (1 << 6) + fn;
        else if (kind == 5)
            w = ops[5] * (1 << 26) + tgt;
        else
            w = ops[kind] * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
        return w;
    endfunction

    task automatic model_reset();
        m_open  = 0;
        m_seen  = 0;
        m_err   = 0;
        m_we    = 0;
        m_cnt   = 0;
        m_addr  = 32'h0;
        m_wdata = 32'h0;
    endtask

    task automatic model_edge();
        bit ready;
        bit xfer;
        bit legal;
        ready = m_open && (m_cnt < DEPTH);
        xfer  = in_valid && ready;
        legal = (int'(in_kind) <= 5);
        m_we  = 0;
        if (xfer) begin
            if (legal) begin
                m_we    = 1;
                m_addr  = 32'h0 + 32'(4 * m_cnt);
                m_wdata = ref_word(int'(in_kind), int'(in_rs), int'(in_rt), int'(in_rd),
                                   int'(in_shamt), int'(in_funct), int'(in_imm), int'(in_target));
                m_cnt++;
            end else begin
                m_err = 1;
            end
        end
        if (m_open) begin
            if (finish || m_cnt == DEPTH) m_open = 0;
        end else if (start) begin
            m_open = 1;
            m_seen = 1;
            m_cnt  = 0;
            m_err  = 0;
        end
    endtask

    task automatic check_all();
        chk("in_ready", 32'(in_ready), 32'(m_open && (m_cnt < DEPTH)));
        chk("imem_we", 32'(imem_we), 32'(m_we));
        chk("imem_addr", imem_addr, m_addr);
        chk("imem_wdata", imem_wdata, m_wdata);
        chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
        chk("done", 32'(done), 32'(m_seen && !m_open));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        start    = 1'b0;
        finish   = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send(input int kind, input int rs, input int rt, input int rd,
                        input int sh, input int fn, input int imm, input int tgt);
        in_valid  = 1'b1;
        in_kind   = 3'(kind);
        in_rs     = 5'(rs);
        in_rt     = 5'(rt);
        in_rd     = 5'(rd);
        in_shamt  = 5'(sh);
        in_funct  = 6'(fn);
        in_imm    = 16'(imm);
        in_target = 26'(tgt);
    endtask

    task automatic new_session();
        finish = 1'b1;
        step();
        start = 1'b1;
        step();
    endtask

    typedef struct {
        bit          new_sess;
        int          kind, rs, rt, rd, sh, fn, imm, tgt;
        logic [31:0] exp_word;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int writes;
        logic [31:0] last_addr;

        n_cmp = 0;
        n_fail = 0;
        vecs[0] = '{1, 0, 16, 8, 0, 0, 0, 4, 0, 32'h8E08_0004, 32'h0};
        vecs[1] = '{1, 1, 16, 8, 0, 0, 0, 8, 0, 32'hAE08_0008, 32'h0};
        vecs[2] = '{0, 2, 8, 9, 10, 0, 32'h20, 0, 0, 32'h0109_5020, 32'h4};
        vecs[3] = '{0, 3, 0, 8, 0, 0, 0, 5, 0, 32'h2008_0005, 32'h8};
        vecs[4] = '{1, 4, 8, 9, 0, 0, 0, 32'hFFFF, 0, 32'h1109_FFFF, 32'h0};
        vecs[5] = '{0, 5, 0, 0, 0, 0, 0, 0, 32'h10, 32'h0800_0010, 32'h4};

        rst = 1'b1;
        start = 1'b0;
        finish = 1'b0;
        in_valid = 1'b0;
        send(0, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Known encodings, back-to-back within a session
        foreach (vecs[i]) begin
            if (vecs[i].new_sess) new_session();
            send(vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh,
                 vecs[i].fn, vecs[i].imm, vecs[i].tgt);
            step();
            chk("tbl_we", 32'(imem_we), 32'h1);
            chk("tbl_wdata", imem_wdata, vecs[i].exp_word);
            chk("tbl_addr", imem_addr, vecs[i].exp_addr);
        end

        // Illegal kind between two legal words
        new_session();
        send(0, 1, 2, 0, 0, 0, 3, 0);
        step();
        send(6, 1, 2, 3, 4, 5, 6, 7);
        step();
        chk("illegal_no_we", 32'(imem_we), 32'h0);
        chk("illegal_err", 32'(err), 32'h1);
        send(1, 3, 4, 0, 0, 0, 12, 0);
        step();
        chk("illegal_next_addr", imem_addr, 32'h4);
        chk("illegal_cnt", 32'(word_cnt), 32'h2);
        chk("illegal_err_sticky", 32'(err), 32'h1);
        new_session();
        chk("start_clears_err", 32'(err), 32'h0);

        // Fill to DEPTH with in_valid held for six words
        writes = 0;
        last_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            send(i % 6, i, i + 1, i + 2, 0, 32'h20, i * 4, i);
            step();
            if (imem_we) begin
                writes++;
                last_addr = imem_addr;
            end
        end
        chk("full_writes", 32'(writes), 32'(DEPTH));
        chk("full_last_addr", last_addr, 32'hC);
        chk("full_ready", 32'(in_ready), 32'h0);
        chk("full_done", 32'(done), 32'h1);

        // finish coinciding with a transfer: write still issues, done already high
        start = 1'b1;
        step();
        send(3, 0, 8, 0, 0, 0, 5, 0);
        finish = 1'b1;
        step();
        chk("fin_xfer_we", 32'(imem_we), 32'h1);
        chk("fin_xfer_wdata", imem_wdata, 32'h2008_0005);
        chk("fin_xfer_done", 32'(done), 32'h1);

        // Reset in the write cycle of a transfer
        start = 1'b1;
        step();
        send(0, 16, 8, 0, 0, 0, 4, 0);
        step();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rst_we", 32'(imem_we), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        step();
        send(1, 16, 8, 0, 0, 0, 8, 0);
        step();
        chk("rst_restart_addr", imem_addr, 32'h0);
        chk("rst_restart_wdata", imem_wdata, 32'hAE08_0008);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            start  = ($urandom_range(0, 9) == 0);
            finish = ($urandom_range(0, 14) == 0);
            send($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63),
                 $urandom_range(0, 65535), $urandom_range(0, 32'h3FF_FFFF));
            in_valid = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
Program-side counterpart of the main control decoder. It accepts instruction fields (kind, registers, immediate, jump target) over a valid/ready handshake and encodes each one into a 32-bit MIPS word. The encoding uses the opcode set the decoder understands: lw, sw, R-type, addi, beq and j. Each encoded word is written sequentially into instruction memory, so benches and boot logic can load programs without hand-assembled hex.

Parameters:
ADDR_W, 32, width of the instruction-memory byte address.
BASE_ADDR, 32'h0000_0000, byte address of the first word written in a load session (word-aligned).
DEPTH, 64, maximum number of words per session (range 1..2^(ADDR_W-2)).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  pulse: opens a load session (honoured in IDLE and DONE only).
finish  input  1  pulse: closes the session (honoured in LOAD only).
in_valid  input  1  instruction fields valid.
in_ready  output  1  block can accept fields this cycle.
in_kind  input  3  0=lw, 1=sw, 2=R-type, 3=addi, 4=beq, 5=j, 6/7=illegal.
in_rs  input  5  source register.
in_rt  input  5  target register.
in_rd  input  5  destination register (R-type only).
in_shamt  input  5  shift amount (R-type only).
in_funct  input  6  function code (R-type only).
in_imm  input  16  immediate or offset (lw/sw/addi/beq).
in_target  input  26  jump target (j only).
imem_we  output  1  one-cycle write strobe.
imem_addr  output  ADDR_W  byte address of the write.
imem_wdata  output  32  encoded instruction.
word_cnt  output  clog2(DEPTH+1)  words written in the current session.
done  output  1  high while in DONE.
err  output  1  sticky: an illegal kind was accepted this session.

Behaviour:
- Reset (async, rst=1): state=IDLE. in_ready, imem_we, done, err = 0. imem_addr=BASE_ADDR, imem_wdata=0, word_cnt=0. A pending write is dropped and no strobe is issued.
- State machine has three states: IDLE, LOAD, DONE.
  - IDLE: in_ready=0. start -> LOAD, clearing word_cnt and err.
  - LOAD: in_ready=1 while word_cnt<DEPTH. start is ignored.
  - DONE: in_ready=0, done=1. start -> LOAD, clearing word_cnt and err.
- Handshake: a transfer occurs when in_valid & in_ready at a rising edge. Fields are sampled at that edge.
- Write latency: 1 cycle. In the cycle after a legal transfer:
  - imem_we=1
  - imem_addr = BASE_ADDR + 4*word_cnt (pre-increment value; wraps modulo 2^ADDR_W)
  - imem_wdata = encoded word
  - word_cnt increments in the same cycle.
- Otherwise imem_we=0, and imem_addr/imem_wdata hold their last values.
- Back-to-back transfers every cycle are supported, giving one write per cycle.
- Encoding, as {field,...} MSB first:
  - lw = {100011, rs, rt, imm}
  - sw = {101011, rs, rt, imm}
  - R-type = {000000, rs, rt, rd, shamt, funct}
  - addi = {001000, rs, rt, imm}
  - beq = {000100, rs, rt, imm}
  - j = {000010, target}
  - Fields unused by a kind are ignored.
- Illegal kind (6/7): the transfer is accepted, nothing is written, word_cnt is unchanged, and err is set (sticky until the next start or rst).
- Full: the transfer that brings the count to DEPTH is written normally, and the state moves to DONE in the following cycle. in_ready drops in the cycle word_cnt reaches DEPTH.
- finish in LOAD -> DONE at the next edge. If finish coincides with a transfer, that transfer is accepted and its write still issues one cycle later, while done is already 1.
- finish outside LOAD and start inside LOAD are ignored.
- Simultaneous start and finish in LOAD: finish wins.

Test Plan:
- Reset, start, then send lw rs=16 rt=8 imm=4 -> next cycle imem_we=1, addr=0x0, wdata=0x8E080004, word_cnt=1.
- Back-to-back in_valid for sw rs=16 rt=8 imm=8, R-type rs=8 rt=9 rd=10 shamt=0 funct=0x20, addi rs=0 rt=8 imm=5:
  - expect writes 0xAE080008 @0x0, 0x01095020 @0x4, 0x20080005 @0x8 on consecutive cycles.
- beq rs=8 rt=9 imm=0xFFFF, then j target=0x0000010 -> 0x1109FFFF @0x0, 0x08000010 @0x4.
- in_kind=6 between two legal words -> no strobe for it, err=1, second legal word lands at addr 0x4. A new start clears err.
- DEPTH=4, stream 6 words with in_valid held -> exactly 4 writes (0x0..0xC), in_ready=0 after the 4th accept, done=1.
- Assert rst in the cycle after a transfer -> no imem_we pulse, all outputs at reset values. A subsequent start restarts writing at BASE_ADDR.
